midi2bus: RTL and testbench
===========================

// Module: midi2bus
// PURPOSE
//  Receive path for the MIDI interface: deserialises the 31250-baud MIDI UART input and parses it into
//  MidiBus channel/system messages plus a SysEx byte stream. Drives the producer side of the MidiBus
//  signal set (cmd/ch/data1/data2/valid, sysex_data/valid/last) consumed by the bus/AXI side on aclk.
//  Single clock domain. A serial-RX sub-module and a message parser share a small SysEx buffer.
// PARAMETERS
//  CLK_FREQ     100_000_000  aclk frequency in Hz
//  BAUD         31250        MIDI line rate
//  OVERSAMPLE   16           RX ticks per bit; tick divider = CLK_FREQ/(BAUD*OVERSAMPLE), exactly 200 at defaults
//  SYSEX_DEPTH  16           SysEx FIFO entries (power of 2); each entry is {last, data[7:0]}
// PORTS
//  aclk          in   1  sole clock
//  aresetn       in   1  asynchronous active-low reset
//  midi_uart_in  in   1  MIDI serial line, idle high, async to aclk
//  midi_cmd      out  4  status[7:4]
//  midi_ch       out  4  status[3:0]; for cmd==4'hF this is the system-message low nibble
//  midi_data1    out  7  first data byte; 0 if the message has none
//  midi_data2    out  7  second data byte; 0 if the message has none
//  midi_valid    out  1  message register holds an unread message
//  midi_rd       in   1  one-cycle pop strobe from the consumer; ignored when midi_valid=0
//  sysex_data    out  8  SysEx FIFO head byte
//  sysex_valid   out  1  SysEx FIFO not empty
//  sysex_last    out  1  head byte is 8'hF7 (end of SysEx)
//  sysex_rd      in   1  pop strobe; ignored when sysex_valid=0
//  rx_frame_err  out  1  one-cycle pulse: stop bit sampled low, byte discarded
//  rx_overflow   out  1  one-cycle pulse: message or SysEx byte dropped because its buffer was full
// BEHAVIOUR
//  Reset: all outputs 0; parser state NO_STATUS; FIFO empty; RX state IDLE.
//  RX input: 2-FF synchroniser on midi_uart_in, then a free-running tick counter.
//   It reloads on each start edge so tick 8 falls mid-bit.
//  RX FSM IDLE->START->DATA->STOP->IDLE.
//   IDLE: synced line 1->0 moves to START.
//   START: at tick 8, line=1 is a glitch and returns to IDLE; otherwise go to DATA.
//   DATA: 8 bits, LSB first, each sampled at tick 8.
//   STOP: sample at tick 8. 1 => byte_valid pulse for 1 cycle; 0 => rx_frame_err pulse.
//   STOP then returns to IDLE. A break (line held low) causes no repeated errors until the line has been high.
//  Parser (consumes one byte per byte_valid):
//   * Realtime F8..FF: posted immediately as a 0-data message (F9/FD dropped). Running status, the partial
//     message and SysEx state are untouched.
//   * 8x,9x,Ax,Bx,Ex: need 2 data bytes. Cx,Dx,F1,F3: need 1. F6: need 0. F2: need 2. F4/F5: dropped.
//     Any of these sets the new status. Running status applies to 8x..Ex only.
//     System common statuses clear running status.
//   * Data byte (bit7=0): fills data1 then data2. When the count is met, the message is posted.
//     Channel messages then re-arm the data count for running status.
//     Data with no status, or system common already complete, is dropped silently.
//   * F0: enters SYSEX and writes F0 to the FIFO with last=0. Data bytes go to the FIFO with last=0.
//     F7 writes F7 with last=1 and exits to NO_STATUS. Realtime inside SysEx does not end it.
//     Any other status inside SysEx first writes a synthesised F7 with last=1 (1 cycle),
//     then is processed normally. F7 outside SysEx is dropped.
//  Message register:
//   * Posting loads cmd/ch/data and sets midi_valid next cycle.
//   * midi_rd clears midi_valid next cycle.
//   * A post while midi_valid=1 and no midi_rd in the same cycle keeps the old message and pulses rx_overflow.
//   * A post with midi_rd in the same cycle replaces the message; midi_valid stays 1.
//  SysEx FIFO:
//   * Write when full: byte dropped, rx_overflow pulse. The synthesised F7 is also subject to this.
//   * Simultaneous read and write when full is allowed; both take effect.
//   * Show-ahead: outputs reflect the head entry combinationally from storage.
//  Reset mid-byte or mid-SysEx discards all partial state; nothing is flushed.
// STRUCTURE
//  Package midi_pkg: typedef midi_msg_t {cmd,ch,data1,data2}.
//   Localparams ST_NOTE_OFF=4'h8 .. ST_PITCH=4'hE, SYS_SOX=8'hF0, SYS_EOX=8'hF7.
//   Function data_len(status) returns 0..2 or -1 for dropped.
//  Sub-module midi_uart_rx (CLK_FREQ, BAUD, OVERSAMPLE) -> rx_data[7:0], rx_valid, rx_frame_err.
//  The parser FSM and the SysEx FIFO stay inline in midi2bus.
// TESTING
//  Bytes 90 3C 64 -> one msg cmd=9 ch=0 d1=3C d2=64; midi_valid holds until midi_rd.
//  Running status 91 40 7F 40 00 with midi_rd after each -> two msgs cmd=9 ch=1 d1=40, d2=7F then 00.
//  Channel realtime: 90 3C F8 64 -> msg cmd=F ch=8 first, then cmd=9 d1=3C d2=64.
//  SysEx realtime: F0 7E F8 01 F7 -> FIFO F0,7E,01,F7(last=1); one realtime msg cmd=F ch=8.
//  F0 7E 01 then 80 40 00 -> FIFO F0,7E,01,F7(last=1); msg cmd=8 d1=40 d2=00.
//  Stop bit forced 0 on byte 90 -> rx_frame_err pulse, no msg; following 3C 64 dropped (no status).
//  Overflow: 17 SysEx bytes with no sysex_rd -> 16 stored, one rx_overflow pulse.
//  Message overflow: second msg while midi_valid=1 and no midi_rd -> first msg kept, rx_overflow pulse.
//  Reset mid-byte: assert aresetn=0 during DATA -> all outputs 0; the next clean 90 3C 64 decodes normally.

Source files
------------

// File: rtl/midi_pkg.sv
// midi_pkg: shared MIDI message types, status constants and the data-length lookup
package midi_pkg;

    typedef struct packed {
        logic [3:0] cmd;
        logic [3:0] ch;
        logic [6:0] data1;
        logic [6:0] data2;
    } midi_msg_t;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {NO_STATUS, CHAN, SYSCOM, SYSEX} parse_state_t;

    localparam logic [3:0] ST_NOTE_OFF = 4'h8;
    localparam logic [3:0] ST_NOTE_ON  = 4'h9;
    localparam logic [3:0] ST_POLY_AT  = 4'hA;
    localparam logic [3:0] ST_CTRL     = 4'hB;
    localparam logic [3:0] ST_PROG     = 4'hC;
    localparam logic [3:0] ST_CH_AT    = 4'hD;
    localparam logic [3:0] ST_PITCH    = 4'hE;
    localparam logic [7:0] SYS_SOX     = 8'hF0;
    localparam logic [7:0] SYS_EOX     = 8'hF7;

    // Data bytes a status needs before posting; -1 means the status is dropped
    function automatic logic signed [2:0] data_len(input logic [7:0] status);
        case (status[7:4])
            ST_NOTE_OFF, ST_NOTE_ON, ST_POLY_AT, ST_CTRL, ST_PITCH: return 3'sd2;
            ST_PROG, ST_CH_AT: return 3'sd1;
            4'hF:
                case (status[3:0])
                    4'h1, 4'h3: return 3'sd1;
                    4'h2: return 3'sd2;
                    4'h6, 4'h8, 4'hA, 4'hB, 4'hC, 4'hE, 4'hF: return 3'sd0;
                    default: return -3'sd1;
                endcase
            default: return -3'sd1;
        endcase
    endfunction

endpackage

// File: rtl/midi_uart_rx.sv
// midi_uart_rx: oversampling 8N1 receiver with mid-bit sampling and frame-error detection
module midi_uart_rx #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 31250,
    parameter int OVERSAMPLE = 16
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err
);
    import midi_pkg::*;

    localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int PW  = $clog2(DIV + 1);
    localparam int TW  = $clog2(OVERSAMPLE);

    logic [2:0]    sync;
    logic [PW-1:0] pre;
    logic [TW-1:0] tcnt;
    logic [2:0]    bit_idx;
    rx_state_t     state;
    logic          line, fall, tick, mid;

    assign line = sync[1];
    assign fall = sync[2] & ~sync[1];
    assign tick = pre == PW'(DIV - 1);
    assign mid  = tick && tcnt == TW'(OVERSAMPLE / 2 - 1);

    // Synchronise the line, run the tick divider and step the frame FSM at each mid-bit sample
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sync         <= 3'b111;
            pre          <= '0;
            tcnt         <= '0;
            bit_idx      <= '0;
            state        <= RX_IDLE;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            sync         <= {sync[1:0], rx};
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            pre          <= tick ? '0 : pre + PW'(1);
            if (tick) tcnt <= tcnt + TW'(1);
            case (state)
                RX_IDLE: if (fall) begin
                    state <= RX_START;
                    pre   <= '0;
                    tcnt  <= '0;
                end
                RX_START: if (mid) begin
                    state   <= line ? RX_IDLE : RX_DATA;
                    bit_idx <= '0;
                end
                RX_DATA: if (mid) begin
                    rx_data <= {line, rx_data[7:1]};
                    bit_idx <= bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state <= RX_STOP;
                end
                RX_STOP: if (mid) begin
                    rx_valid     <= line;
                    rx_frame_err <= ~line;
                    state        <= RX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/midi2bus.sv
// midi2bus: MIDI receive path producing MidiBus messages and a SysEx byte stream
module midi2bus #(
    parameter int CLK_FREQ    = 100_000_000,
    parameter int BAUD        = 31250,
    parameter int OVERSAMPLE  = 16,
    parameter int SYSEX_DEPTH = 16
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       midi_uart_in,
    output logic [3:0] midi_cmd,
    output logic [3:0] midi_ch,
    output logic [6:0] midi_data1,
    output logic [6:0] midi_data2,
    output logic       midi_valid,
    input  logic       midi_rd,
    output logic [7:0] sysex_data,
    output logic       sysex_valid,
    output logic       sysex_last,
    input  logic       sysex_rd,
    output logic       rx_frame_err,
    output logic       rx_overflow
);
    import midi_pkg::*;

    localparam int AW = $clog2(SYSEX_DEPTH);

    logic [7:0]        rx_data, status, pend_b, in_b;
    logic              rx_valid, pend_v, in_v, got, need2, post, wr, full, pop, push;
    logic signed [2:0] len;
    logic [6:0]        d1;
    logic [8:0]        wr_data;
    logic [8:0]        mem [SYSEX_DEPTH];
    logic [AW:0]       wp, rp;
    parse_state_t      pstate;
    midi_msg_t         post_msg, msg;

    midi_uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OVERSAMPLE)) u_rx (
        .aclk(aclk), .aresetn(aresetn), .rx(midi_uart_in),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_frame_err(rx_frame_err)
    );

    // A status that interrupts SysEx is held one cycle while the closing F7 is written
    assign in_v = rx_valid | pend_v;
    assign in_b = pend_v ? pend_b : rx_data;
    assign len  = data_len(in_b);

    // Parser: each byte becomes a message post, a SysEx FIFO write, or a state update
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pstate <= NO_STATUS; status <= '0; d1 <= '0; got <= 1'b0; need2 <= 1'b0;
            pend_v <= 1'b0; pend_b <= '0; post <= 1'b0; post_msg <= '0; wr <= 1'b0; wr_data <= '0;
        end else begin
            post   <= 1'b0;
            wr     <= 1'b0;
            pend_v <= 1'b0;
            if (in_v) begin
                if (in_b >= 8'hF8) begin
                    post     <= len == 3'sd0;
                    post_msg <= '{4'hF, in_b[3:0], 7'd0, 7'd0};
                end else if (pstate == SYSEX && in_b[7] && in_b != SYS_EOX) begin
                    wr      <= 1'b1;
                    wr_data <= {1'b1, SYS_EOX};
                    pstate  <= NO_STATUS;
                    pend_v  <= 1'b1;
                    pend_b  <= in_b;
                end else if (in_b == SYS_EOX) begin
                    if (pstate == SYSEX) begin
                        wr      <= 1'b1;
                        wr_data <= {1'b1, SYS_EOX};
                        pstate  <= NO_STATUS;
                    end
                end else if (pstate == SYSEX) begin
                    wr      <= 1'b1;
                    wr_data <= {1'b0, in_b};
                end else if (in_b == SYS_SOX) begin
                    wr      <= 1'b1;
                    wr_data <= {1'b0, SYS_SOX};
                    pstate  <= SYSEX;
                end else if (in_b[7]) begin
                    if (len == 3'sd0) begin
                        post     <= 1'b1;
                        post_msg <= '{in_b[7:4], in_b[3:0], 7'd0, 7'd0};
                        pstate   <= NO_STATUS;
                    end else if (len > 3'sd0) begin
                        status <= in_b;
                        need2  <= len == 3'sd2;
                        got    <= 1'b0;
                        pstate <= in_b[7:4] == 4'hF ? SYSCOM : CHAN;
                    end
                end else if (pstate != NO_STATUS) begin
                    if (need2 && !got) begin
                        d1  <= in_b[6:0];
                        got <= 1'b1;
                    end else begin
                        post     <= 1'b1;
                        post_msg <= '{status[7:4], status[3:0], got ? d1 : in_b[6:0], got ? in_b[6:0] : 7'd0};
                        got      <= 1'b0;
                        if (pstate == SYSCOM) pstate <= NO_STATUS;
                    end
                end
            end
        end
    end

    // Message register: an unread message is kept unless the consumer reads in the same cycle
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            msg        <= '0;
            midi_valid <= 1'b0;
        end else if (post && (!midi_valid || midi_rd)) begin
            msg        <= post_msg;
            midi_valid <= 1'b1;
        end else if (midi_rd) begin
            midi_valid <= 1'b0;
        end
    end

    assign midi_cmd   = msg.cmd;
    assign midi_ch    = msg.ch;
    assign midi_data1 = msg.data1;
    assign midi_data2 = msg.data2;

    assign sysex_valid = wp != rp;
    assign full        = (wp ^ rp) == {1'b1, {AW{1'b0}}};
    assign pop         = sysex_rd && sysex_valid;
    assign push        = wr && (!full || pop);
    assign {sysex_last, sysex_data} = sysex_valid ? mem[rp[AW-1:0]] : 9'd0;

    // SysEx storage; a write into a full FIFO that is also popping reuses the head slot
    always_ff @(posedge aclk) begin
        if (push) mem[wp[AW-1:0]] <= wr_data;
    end

    // SysEx pointers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wp <= '0;
            rp <= '0;
        end else begin
            wp <= wp + {{AW{1'b0}}, push};
            rp <= rp + {{AW{1'b0}}, pop};
        end
    end

    // Overflow pulse when a post or a SysEx write finds its buffer full
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) rx_overflow <= 1'b0;
        else          rx_overflow <= (post && midi_valid && !midi_rd) || (wr && full && !pop);
    end

endmodule

// File: tb/tb_midi2bus.sv
// tb_midi2bus: scoreboard bench driving serial MIDI bytes against a behavioural parser model
module tb_midi2bus;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 31250;
    localparam int BIT      = CLK_FREQ / BAUD;
    localparam int GAP      = 8;

    logic       aclk, aresetn, uart, midi_rd, sysex_rd;
    logic [3:0] midi_cmd, midi_ch;
    logic [6:0] midi_data1, midi_data2;
    logic       midi_valid, sysex_valid, sysex_last, rx_frame_err, rx_overflow;
    logic [7:0] sysex_data;
    logic [21:0] cur_msg;

    int errors = 0, checks = 0, fe_n = 0, ovf_n = 0;
    bit auto_rd, auto_sx;
    logic [21:0] msg_q[$];
    logic [8:0]  sx_q[$];
    int run_st = -1;
    int dat[$];
    bit in_sx;
    logic [7:0] rt_tab [8] = '{8'hF8, 8'hFA, 8'hFB, 8'hFC, 8'hFE, 8'hFF, 8'hF9, 8'hFD};
    logic [7:0] sc_tab [6] = '{8'hF1, 8'hF2, 8'hF3, 8'hF6, 8'hF4, 8'hF5};

    midi2bus #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(16), .SYSEX_DEPTH(16)) dut (
        .aclk(aclk), .aresetn(aresetn), .midi_uart_in(uart),
        .midi_cmd(midi_cmd), .midi_ch(midi_ch), .midi_data1(midi_data1), .midi_data2(midi_data2),
        .midi_valid(midi_valid), .midi_rd(midi_rd),
        .sysex_data(sysex_data), .sysex_valid(sysex_valid), .sysex_last(sysex_last), .sysex_rd(sysex_rd),
        .rx_frame_err(rx_frame_err), .rx_overflow(rx_overflow)
    );

    assign cur_msg = {midi_cmd, midi_ch, midi_data1, midi_data2};

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        #1_200_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    always @(negedge aclk) begin
        if (rx_frame_err) fe_n <= fe_n + 1;
        if (rx_overflow) ovf_n <= ovf_n + 1;
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: MIDI parsing rules expressed over a status value and a data list
    function automatic int need_of(input int s);
        if ((s >= 'h80 && s < 'hC0) || (s >= 'hE0 && s < 'hF0)) return 2;
        if (s >= 'hC0 && s < 'hE0) return 1;
        if (s == 'hF1 || s == 'hF3) return 1;
        if (s == 'hF2) return 2;
        if (s == 'hF6) return 0;
        return -1;
    endfunction

    task automatic push_msg(input int s, input int a, input int b);
        logic [21:0] e;
        e = {8'(s), 7'(a), 7'(b)};
        msg_q.push_back(e);
    endtask

    task automatic model(input int b);
        if (b >= 'hF8) begin
            if (b != 'hF9 && b != 'hFD) push_msg(b, 0, 0);
            return;
        end
        if (in_sx) begin
            if (b < 'h80) begin
                sx_q.push_back({1'b0, 8'(b)});
                return;
            end
            sx_q.push_back(9'h1F7);
            in_sx = 0;
            run_st = -1;
            if (b == 'hF7) return;
        end
        if (b == 'hF0) begin
            in_sx = 1;
            run_st = -1;
            sx_q.push_back(9'h0F0);
            return;
        end
        if (b >= 'h80) begin
            if (need_of(b) == 0) begin
                push_msg(b, 0, 0);
                run_st = -1;
            end else if (need_of(b) > 0) begin
                run_st = b;
                dat.delete();
            end
            return;
        end
        if (run_st < 0) return;
        dat.push_back(b);
        if (dat.size() == need_of(run_st)) begin
            push_msg(run_st, dat[0], dat.size() > 1 ? dat[1] : 0);
            dat.delete();
            if (run_st >= 'hF0) run_st = -1;
        end
    endtask

    task automatic model_reset();
        msg_q.delete();
        sx_q.delete();
        dat.delete();
        run_st = -1;
        in_sx = 0;
    endtask

    task automatic tx(input logic [7:0] b, input bit stop_ok);
        uart = 1'b0;
        repeat (BIT) @(negedge aclk);
        for (int i = 0; i < 8; i++) begin
            uart = b[i];
            repeat (BIT) @(negedge aclk);
        end
        uart = stop_ok;
        repeat (BIT) @(negedge aclk);
        uart = 1'b1;
        repeat (GAP) @(negedge aclk);
    endtask

    task automatic send(input logic [7:0] b);
        model(int'(b));
        tx(b, 1'b1);
    endtask

    // Message monitor: pops and compares whenever the DUT presents a message
    initial begin
        logic [21:0] e;
        midi_rd = 1'b0;
        forever begin
            @(negedge aclk);
            midi_rd = 1'b0;
            if (aresetn && auto_rd && midi_valid) begin
                checks++;
                if (msg_q.size() == 0) begin
                    errors++;
                    $display("FAIL msg: unexpected message %h", cur_msg);
                end else begin
                    e = msg_q.pop_front();
                    if (cur_msg !== e) begin
                        errors++;
                        $display("FAIL msg: got %h expected %h", cur_msg, e);
                    end
                end
                midi_rd = 1'b1;
            end
        end
    end

    // SysEx monitor: pops and compares each head byte
    initial begin
        logic [8:0] e;
        sysex_rd = 1'b0;
        forever begin
            @(negedge aclk);
            sysex_rd = 1'b0;
            if (aresetn && auto_sx && sysex_valid) begin
                checks++;
                if (sx_q.size() == 0) begin
                    errors++;
                    $display("FAIL sysex: unexpected byte %h last=%b", sysex_data, sysex_last);
                end else begin
                    e = sx_q.pop_front();
                    if ({sysex_last, sysex_data} !== e) begin
                        errors++;
                        $display("FAIL sysex: got %h expected %h", {sysex_last, sysex_data}, e);
                    end
                end
                sysex_rd = 1'b1;
            end
        end
    end

    initial begin
        int base;
        uart = 1'b1;
        auto_rd = 1'b1;
        auto_sx = 1'b1;
        aresetn = 1'b0;
        repeat (5) @(negedge aclk);
        chk("reset_msg", int'({cur_msg, midi_valid}), 0);
        chk("reset_sysex", int'({sysex_data, sysex_valid, sysex_last, rx_frame_err, rx_overflow}), 0);
        aresetn = 1'b1;
        repeat (5) @(negedge aclk);

        base = fe_n;
        tx(8'h90, 1'b0);
        chk("frame_err_pulse", fe_n - base, 1);
        send(8'h3C);
        send(8'h64);
        chk("orphan_data_dropped", int'(midi_valid), 0);

        auto_rd = 1'b0;
        send(8'h90); send(8'h3C); send(8'h64);
        repeat (50) @(negedge aclk);
        chk("hold_valid", int'(midi_valid), 1);
        chk("hold_msg", int'(cur_msg), int'({8'h90, 7'h3C, 7'h64}));
        auto_rd = 1'b1;
        repeat (5) @(negedge aclk);
        chk("hold_cleared", int'(midi_valid), 0);

        send(8'h91); send(8'h40); send(8'h7F); send(8'h40); send(8'h00);
        send(8'h90); send(8'h3C); send(8'hF8); send(8'h64);
        send(8'hF0); send(8'h7E); send(8'hF8); send(8'h01); send(8'hF7);
        send(8'hF0); send(8'h7E); send(8'h01); send(8'h80); send(8'h40); send(8'h00);

        auto_rd = 1'b0;
        base = ovf_n;
        send(8'h92); send(8'h10); send(8'h20); send(8'h30); send(8'h40);
        void'(msg_q.pop_back());
        chk("msg_ovf_pulse", ovf_n - base, 1);
        chk("msg_ovf_kept", int'(cur_msg), int'({8'h92, 7'h10, 7'h20}));
        auto_rd = 1'b1;
        repeat (5) @(negedge aclk);

        auto_sx = 1'b0;
        base = ovf_n;
        send(8'hF0);
        for (int i = 1; i <= 16; i++) send(8'(i));
        void'(sx_q.pop_back());
        chk("sysex_ovf_pulse", ovf_n - base, 1);
        chk("sysex_ovf_head", int'({sysex_last, sysex_data}), 'h0F0);
        auto_sx = 1'b1;
        repeat (40) @(negedge aclk);
        send(8'hF7);

        auto_rd = 1'b0;
        send(8'hF8); send(8'h90); send(8'h3C);
        uart = 1'b0;
        repeat (BIT) @(negedge aclk);
        uart = 1'b1;
        repeat (2 * BIT) @(negedge aclk);
        uart = 1'b0;
        repeat (BIT / 2) @(negedge aclk);
        aresetn = 1'b0;
        @(negedge aclk);
        chk("midrst_valid", int'(midi_valid), 0);
        chk("midrst_msg", int'(cur_msg), 0);
        chk("midrst_sysex", int'({sysex_data, sysex_valid, sysex_last, rx_frame_err, rx_overflow}), 0);
        model_reset();
        uart = 1'b1;
        repeat (5) @(negedge aclk);
        aresetn = 1'b1;
        auto_rd = 1'b1;
        repeat (5) @(negedge aclk);
        send(8'h90); send(8'h3C); send(8'h64);

        for (int i = 0; i < 120; i++) begin
            int r;
            logic [7:0] b;
            r = int'($urandom_range(0, 99));
            if (r < 45)      b = 8'($urandom_range(0, 127));
            else if (r < 70) b = 8'($urandom_range(128, 239));
            else if (r < 76) b = 8'hF0;
            else if (r < 80) b = 8'hF7;
            else if (r < 90) b = rt_tab[$urandom_range(0, 7)];
            else             b = sc_tab[$urandom_range(0, 5)];
            send(b);
        end

        repeat (50) @(negedge aclk);
        chk("msg_queue_drained", msg_q.size(), 0);
        chk("sysex_queue_drained", sx_q.size(), 0);
        chk("frame_err_total", fe_n, 1);
        chk("overflow_total", ovf_n, 2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
